// File: rtl/pmp_multiport_pkg.sv
// Shared PMP types: cfg byte layout, address-matching modes, CSR numbers, access encodings.
package cep_define;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_a_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    typedef enum logic [1:0] {
        OPER_READ  = 2'd0,
        OPER_WRITE = 2'd1,
        OPER_EXEC  = 2'd2
    } pmp_oper_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } pmp_size_e;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Reserved bits read back as zero and the W-without-R combination collapses to no access.
    function automatic pmpcfg_t pmpcfg_sanitize(input logic [7:0] b);
        pmpcfg_t c;
        c      = pmpcfg_t'(b);
        c.rsvd = 2'b00;
        if (!c.r && c.w) c.w = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pmp_multiport_if.sv
// Per-port access-check request/response bundle; responses follow requests by one cycle, no backpressure.
interface pmp_multiport_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]       req_valid;
    logic [NUM_PORTS-1:0][31:0] req_addr;
    logic [NUM_PORTS-1:0][1:0]  req_oper;
    logic [NUM_PORTS-1:0][1:0]  req_size;
    logic [NUM_PORTS-1:0][1:0]  req_priv;
    logic [NUM_PORTS-1:0]       rsp_valid;
    logic [NUM_PORTS-1:0]       rsp_fault;

    modport master (
        output req_valid, req_addr, req_oper, req_size, req_priv,
        input  rsp_valid, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, req_oper, req_size, req_priv,
        output rsp_valid, rsp_fault
    );
endinterface

// File: rtl/pmp_region_match.sv
// One PMP entry against one access span; purely combinational, no backpressure.
module pmp_region_match
    import cep_define::*;
(
    input  pmp_a_e      a,
    input  logic [29:0] addr_cur,
    input  logic [29:0] addr_prev,
    input  logic [31:0] span_lo,
    input  logic [32:0] span_hi,
    output logic        any_hit,
    output logic        full_hit
);
    logic [31:0] cur_w;
    logic [31:0] mask_w;
    logic [35:0] rlo;
    logic [35:0] rhi;
    logic [35:0] slo;
    logic [35:0] shi;
    logic        rvalid;

    // mask_w has t+1 low ones for t trailing ones; an all-ones entry yields a 2^33-byte region
    assign cur_w  = {2'b00, addr_cur};
    assign mask_w = cur_w ^ (cur_w + 32'd1);

    always_comb begin
        rlo    = '0;
        rhi    = '0;
        rvalid = 1'b0;
        case (a)
            PMP_TOR: begin
                rlo    = {4'b0, addr_prev, 2'b00};
                rhi    = {4'b0, addr_cur, 2'b00};
                rvalid = rlo < rhi;
            end
            PMP_NA4: begin
                rlo    = {4'b0, addr_cur, 2'b00};
                rhi    = rlo + 36'd4;
                rvalid = 1'b1;
            end
            PMP_NAPOT: begin
                rlo    = {2'b00, cur_w & ~mask_w, 2'b00};
                rhi    = rlo + {1'b0, {1'b0, mask_w} + 33'd1, 2'b00};
                rvalid = 1'b1;
            end
            default: rvalid = 1'b0;
        endcase
    end

    // Span is converted to a half-open interval so both tests compare like with like
    assign slo      = {4'b0, span_lo};
    assign shi      = {3'b0, span_hi} + 36'd1;
    assign any_hit  = rvalid && (slo < rhi) && (shi > rlo);
    assign full_hit = rvalid && (slo >= rlo) && (shi <= rhi);

endmodule

// File: rtl/pmp_multiport.sv
// Multi-port PMP checker with CSR-programmable entries and a sticky first-fault register.
// Responses registered one cycle after the request; no backpressure, every request is answered.
module pmp_multiport
    import cep_define::*;
#(
    parameter int NUM_REGIONS = 8,
    parameter int NUM_PORTS   = 2,
    parameter int PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [31:0]       rw_addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    pmp_multiport_if.slave    bus,
    output logic              fault_valid,
    output logic [31:0]       fault_addr,
    output logic [PORT_W-1:0] fault_port,
    output logic [1:0]        fault_oper,
    input  logic              fault_clr
);
    localparam int NUM_CFG = NUM_REGIONS / 4;

    pmpcfg_t              cfg_q     [NUM_REGIONS];
    logic    [29:0]       addr_q    [NUM_REGIONS];
    logic    [29:0]       prev_addr [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] addr_wr_ok;
    logic [11:0]          csr;
    logic                 any_active;
    logic [NUM_PORTS-1:0] port_fault;
    logic [NUM_PORTS-1:0] new_fault;
    logic [31:0]          sel_addr;
    logic [PORT_W-1:0]    sel_port;
    logic [1:0]           sel_oper;
    logic                 unused_rw_hi;

    assign csr          = rw_addr[11:0];
    assign unused_rw_hi = ^rw_addr[31:12];

    // A locked TOR entry also freezes the address below it, since that address is its base
    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_entry
        if (i + 1 < NUM_REGIONS) begin : g_mid
            assign addr_wr_ok[i] = !cfg_q[i].l && !(cfg_q[i+1].l && cfg_q[i+1].a == PMP_TOR);
        end else begin : g_last
            assign addr_wr_ok[i] = !cfg_q[i].l;
        end
        if (i == 0) begin : g_first
            assign prev_addr[i] = '0;
        end else begin : g_rest
            assign prev_addr[i] = addr_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int n = 0; n < NUM_CFG; n++) begin
                if (csr == CSR_PMPCFG0 + 12'(n)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (!cfg_q[4*n+k].l) cfg_q[4*n+k] <= pmpcfg_sanitize(wdata[8*k +: 8]);
                    end
                end
            end
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (csr == CSR_PMPADDR0 + 12'(i) && addr_wr_ok[i]) addr_q[i] <= wdata[29:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int n = 0; n < NUM_CFG; n++) begin
            if (csr == CSR_PMPCFG0 + 12'(n))
                rdata = {cfg_q[4*n+3], cfg_q[4*n+2], cfg_q[4*n+1], cfg_q[4*n]};
        end
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (csr == CSR_PMPADDR0 + 12'(i)) rdata = {2'b00, addr_q[i]};
        end
    end

    always_comb begin
        any_active = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (cfg_q[i].a != PMP_OFF) any_active = 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [31:0]            a;
        logic [1:0]             oper;
        logic [1:0]             size;
        logic [1:0]             priv;
        logic [1:0]             len_m1;
        logic                   misalign;
        logic                   bad;
        logic [32:0]            span_hi;
        logic [NUM_REGIONS-1:0] any_hit;
        logic [NUM_REGIONS-1:0] full_hit;
        logic                   found;
        logic                   sel_full;
        pmpcfg_t                sel_cfg;
        logic                   perm;
        logic                   fault;

        assign a    = bus.req_addr[p];
        assign oper = bus.req_oper[p];
        assign size = bus.req_size[p];
        assign priv = bus.req_priv[p];

        always_comb begin
            len_m1   = 2'd0;
            misalign = 1'b0;
            case (size)
                SIZE_HALF: begin len_m1 = 2'd1; misalign = a[0];    end
                SIZE_WORD: begin len_m1 = 2'd3; misalign = |a[1:0]; end
                default:   len_m1 = 2'd0;
            endcase
        end

        assign bad     = misalign || (size == 2'b11) || (oper == 2'b11);
        assign span_hi = {1'b0, a} + {31'b0, len_m1};

        for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_match
            pmp_region_match u_match (
                .a         (cfg_q[i].a),
                .addr_cur  (addr_q[i]),
                .addr_prev (prev_addr[i]),
                .span_lo   (a),
                .span_hi   (span_hi),
                .any_hit   (any_hit[i]),
                .full_hit  (full_hit[i])
            );
        end

        // Scanning downwards leaves the lowest-index hit as the deciding entry
        always_comb begin
            found    = 1'b0;
            sel_full = 1'b0;
            sel_cfg  = '0;
            for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
                if (any_hit[i]) begin
                    found    = 1'b1;
                    sel_full = full_hit[i];
                    sel_cfg  = cfg_q[i];
                end
            end
            case (oper)
                OPER_READ:  perm = sel_cfg.r;
                OPER_WRITE: perm = sel_cfg.w;
                OPER_EXEC:  perm = sel_cfg.x;
                default:    perm = 1'b0;
            endcase
            if (bad)                                 fault = 1'b1;
            else if (found && !sel_full)             fault = 1'b1;
            else if (found && priv == PRIV_M && !sel_cfg.l) fault = 1'b0;
            else if (found)                          fault = !perm;
            else                                     fault = (priv != PRIV_M) && any_active;
        end

        assign port_fault[p] = fault;
    end

    assign new_fault = bus.req_valid & port_fault;

    always_comb begin
        sel_addr = '0;
        sel_port = '0;
        sel_oper = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (new_fault[p]) begin
                sel_addr = bus.req_addr[p];
                sel_port = PORT_W'(p);
                sel_oper = bus.req_oper[p];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.rsp_valid <= '0;
            bus.rsp_fault <= '0;
            fault_valid   <= 1'b0;
            fault_addr    <= '0;
            fault_port    <= '0;
            fault_oper    <= '0;
        end else begin
            bus.rsp_valid <= bus.req_valid;
            bus.rsp_fault <= new_fault;
            if (|new_fault && (!fault_valid || fault_clr)) begin
                fault_valid <= 1'b1;
                fault_addr  <= sel_addr;
                fault_port  <= sel_port;
                fault_oper  <= sel_oper;
            end else if (fault_clr) begin
                fault_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pmp_multiport.sv
// Vector-table and scoreboard bench for the two-port, eight-entry PMP checker.
module tb_pmp_multiport;
    import cep_define::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] rw_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic [0:0]  fault_port;
    logic [1:0]  fault_oper;
    logic        fault_clr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int   port;
        logic fault;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  oper;
        logic [1:0]  size;
        logic [1:0]  priv;
        logic        fault;
    } vec_t;

    exp_t exp_q[$];
    vec_t tab[$];

    pmp_multiport_if #(.NUM_PORTS(2)) bus ();

    pmp_multiport #(.NUM_REGIONS(8), .NUM_PORTS(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .rw_addr     (rw_addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .bus         (bus.slave),
        .fault_valid (fault_valid),
        .fault_addr  (fault_addr),
        .fault_port  (fault_port),
        .fault_oper  (fault_oper),
        .fault_clr   (fault_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rsp();
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            if (bus.rsp_valid[p]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: port %0d responded with nothing outstanding", p);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_port", p, e.port);
                    chk("rsp_fault", {31'b0, bus.rsp_fault[p]}, {31'b0, e.fault});
                end
            end else begin
                chk("rsp_fault_idle", {31'b0, bus.rsp_fault[p]}, 32'd0);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        check_rsp();
        bus.req_valid = '0;
        wr_en         = 1'b0;
        fault_clr     = 1'b0;
    endtask

    task automatic drive(input int p, input logic [31:0] a, input logic [1:0] oper,
                         input logic [1:0] size, input logic [1:0] priv, input logic exp_fault);
        exp_t e;
        bus.req_valid[p] = 1'b1;
        bus.req_addr[p]  = a;
        bus.req_oper[p]  = oper;
        bus.req_size[p]  = size;
        bus.req_priv[p]  = priv;
        e.port  = p;
        e.fault = exp_fault;
        exp_q.push_back(e);
    endtask

    task automatic csr_wr(input logic [31:0] addr, input logic [31:0] data);
        rw_addr = addr;
        wdata   = data;
        wr_en   = 1'b1;
        cycle();
    endtask

    task automatic csr_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        rw_addr = addr;
        #1;
        chk(name, rdata, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [1:0] o, input logic [1:0] s,
                                input logic [1:0] pv, input logic f);
        vec_t v;
        v.addr = a; v.oper = o; v.size = s; v.priv = pv; v.fault = f;
        return v;
    endfunction

    // Applies the table one vector per cycle on alternating ports, then checks the first capture
    task automatic run_table(input string name);
        int first;
        first     = -1;
        fault_clr = 1'b1;
        cycle();
        chk({name, "_clr_valid"}, {31'b0, fault_valid}, 32'd0);
        for (int i = 0; i < tab.size(); i++) begin
            drive(i % 2, tab[i].addr, tab[i].oper, tab[i].size, tab[i].priv, tab[i].fault);
            if (tab[i].fault && first < 0) first = i;
            cycle();
        end
        if (first >= 0) begin
            chk({name, "_fault_valid"}, {31'b0, fault_valid}, 32'd1);
            chk({name, "_fault_addr"}, fault_addr, tab[first].addr);
            chk({name, "_fault_port"}, {31'b0, fault_port}, first % 2);
            chk({name, "_fault_oper"}, {30'b0, fault_oper}, {30'b0, tab[first].oper});
        end
        tab.delete();
    endtask

    initial begin
        reset         = 1'b1;
        wr_en         = 1'b0;
        rw_addr       = '0;
        wdata         = '0;
        fault_clr     = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_oper  = '0;
        bus.req_size  = '0;
        bus.req_priv  = '0;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state
        csr_chk("rst_cfg0", 32'h3A0, 32'h0);
        csr_chk("rst_cfg1", 32'h3A1, 32'h0);
        csr_chk("rst_addr0", 32'h3B0, 32'h0);
        csr_chk("rst_addr7", 32'h3B7, 32'h0);
        chk("rst_rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
        chk("rst_fault_valid", {31'b0, fault_valid}, 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        chk("rst_fault_port", {31'b0, fault_port}, 32'd0);
        chk("rst_fault_oper", {30'b0, fault_oper}, 32'd0);
        drive(0, 32'h0, OPER_READ, SIZE_WORD, PRIV_S, 1'b0);
        cycle();

        // Entry 0: TOR [0, 0x1000), execute only
        csr_wr(32'h3B0, 32'h0000_0400);
        csr_wr(32'h3A0, 32'h0000_000C);
        csr_chk("tor_addr0", 32'h3B0, 32'h0000_0400);
        csr_chk("tor_cfg0", 32'h3A0, 32'h0000_000C);
        tab.push_back(mk(32'h0FFC, OPER_EXEC,  SIZE_WORD, PRIV_U, 1'b0));
        tab.push_back(mk(32'h0FFC, OPER_READ,  SIZE_WORD, PRIV_U, 1'b1));
        tab.push_back(mk(32'h1000, OPER_EXEC,  SIZE_WORD, PRIV_U, 1'b1));
        tab.push_back(mk(32'h0FFC, OPER_READ,  SIZE_WORD, PRIV_M, 1'b0));
        tab.push_back(mk(32'h2000, OPER_READ,  SIZE_WORD, PRIV_M, 1'b0));
        tab.push_back(mk(32'h0FFE, OPER_EXEC,  SIZE_HALF, PRIV_U, 1'b0));
        tab.push_back(mk(32'h0FFD, OPER_EXEC,  SIZE_HALF, PRIV_U, 1'b1));
        tab.push_back(mk(32'h0000, OPER_EXEC,  2'b11,     PRIV_U, 1'b1));
        tab.push_back(mk(32'h0000, 2'b11,      SIZE_WORD, PRIV_U, 1'b1));
        tab.push_back(mk(32'h0000, OPER_WRITE, SIZE_BYTE, PRIV_S, 1'b1));
        tab.push_back(mk(32'h1001, OPER_EXEC,  SIZE_WORD, PRIV_M, 1'b1));
        run_table("tor");
        fault_clr = 1'b1;
        drive(0, 32'h1000, OPER_EXEC, SIZE_WORD, PRIV_U, 1'b1);
        cycle();
        chk("tor_clr_addr", fault_addr, 32'h1000);
        chk("tor_clr_oper", {30'b0, fault_oper}, 32'd2);
        chk("tor_clr_port", {31'b0, fault_port}, 32'd0);

        // Entry 1: NAPOT 8 KiB at 0, read only; reserved bits and W-only byte sanitised
        csr_wr(32'h3B1, 32'h0000_03FF);
        csr_wr(32'h3A0, 32'h6200_1900);
        csr_chk("napot_cfg0", 32'h3A0, 32'h0000_1900);
        csr_wr(32'h3B3, 32'hFFFF_FFFF);
        csr_chk("addr_hi_bits", 32'h3B3, 32'h3FFF_FFFF);
        tab.push_back(mk(32'h1FFE, OPER_READ,  SIZE_WORD, PRIV_U, 1'b1));
        tab.push_back(mk(32'h1FFC, OPER_READ,  SIZE_WORD, PRIV_U, 1'b0));
        tab.push_back(mk(32'h2000, OPER_READ,  SIZE_WORD, PRIV_U, 1'b1));
        tab.push_back(mk(32'h0000, OPER_WRITE, SIZE_WORD, PRIV_U, 1'b1));
        tab.push_back(mk(32'h0100, OPER_EXEC,  SIZE_WORD, PRIV_U, 1'b1));
        tab.push_back(mk(32'h0000, OPER_READ,  SIZE_BYTE, PRIV_S, 1'b0));
        tab.push_back(mk(32'h2000, OPER_WRITE, SIZE_WORD, PRIV_M, 1'b0));
        tab.push_back(mk(32'h0000, OPER_WRITE, SIZE_WORD, PRIV_M, 1'b0));
        tab.push_back(mk(32'h1FFF, OPER_READ,  SIZE_BYTE, PRIV_U, 1'b0));
        run_table("napot");

        // Locking: entry 2 NA4 at 0x100 locked, entry 5 locked TOR freezes pmpaddr4
        csr_wr(32'h3A0, 32'h0000_0000);
        csr_wr(32'h3B2, 32'h0000_0040);
        csr_wr(32'h3A0, 32'h0090_0000);
        csr_wr(32'h3A0, 32'h0007_0001);
        csr_chk("lock_cfg0", 32'h3A0, 32'h0090_0001);
        csr_wr(32'h3B2, 32'h0000_0055);
        csr_chk("lock_addr2", 32'h3B2, 32'h0000_0040);
        csr_chk("addr_hi_decode", 32'h0001_03B2, 32'h0000_0040);
        csr_wr(32'h3B4, 32'h0000_0100);
        csr_wr(32'h3B5, 32'h0000_0200);
        csr_wr(32'h3A1, 32'h0000_8900);
        csr_wr(32'h3B4, 32'h0000_0111);
        csr_chk("tor_lock_addr4", 32'h3B4, 32'h0000_0100);
        csr_wr(32'h3B5, 32'h0000_0300);
        csr_chk("tor_lock_addr5", 32'h3B5, 32'h0000_0200);
        csr_wr(32'h3A2, 32'h0000_00FF);
        csr_chk("unmapped_cfg2", 32'h3A2, 32'h0);
        csr_chk("unmapped_addr8", 32'h3B8, 32'h0);
        tab.push_back(mk(32'h0100, OPER_READ,  SIZE_WORD, PRIV_M, 1'b1));
        tab.push_back(mk(32'h0104, OPER_READ,  SIZE_WORD, PRIV_M, 1'b0));
        tab.push_back(mk(32'h0104, OPER_READ,  SIZE_WORD, PRIV_U, 1'b1));
        tab.push_back(mk(32'h0400, OPER_WRITE, SIZE_WORD, PRIV_M, 1'b1));
        tab.push_back(mk(32'h07FC, OPER_READ,  SIZE_WORD, PRIV_M, 1'b0));
        tab.push_back(mk(32'h0500, OPER_READ,  SIZE_HALF, PRIV_U, 1'b0));
        tab.push_back(mk(32'h0800, OPER_READ,  SIZE_WORD, PRIV_M, 1'b0));
        tab.push_back(mk(32'h03FC, OPER_READ,  SIZE_WORD, PRIV_S, 1'b1));
        run_table("lock");

        // Sticky fault register: clear, simultaneous faults, clear with new fault, hold
        fault_clr = 1'b1;
        cycle();
        chk("clr_valid", {31'b0, fault_valid}, 32'd0);
        chk("clr_addr_held", fault_addr, 32'h0100);
        drive(0, 32'h0500, OPER_WRITE, SIZE_WORD, PRIV_U, 1'b1);
        drive(1, 32'h0600, OPER_WRITE, SIZE_WORD, PRIV_U, 1'b1);
        cycle();
        chk("dual_port", {31'b0, fault_port}, 32'd0);
        chk("dual_addr", fault_addr, 32'h0500);
        chk("dual_oper", {30'b0, fault_oper}, 32'd1);
        drive(0, 32'h0704, OPER_READ,  SIZE_WORD, PRIV_U, 1'b0);
        drive(1, 32'h0704, OPER_WRITE, SIZE_WORD, PRIV_U, 1'b1);
        fault_clr = 1'b1;
        cycle();
        chk("reclr_valid", {31'b0, fault_valid}, 32'd1);
        chk("reclr_port", {31'b0, fault_port}, 32'd1);
        chk("reclr_addr", fault_addr, 32'h0704);
        drive(0, 32'h0408, OPER_WRITE, SIZE_WORD, PRIV_U, 1'b1);
        cycle();
        chk("sticky_hold_addr", fault_addr, 32'h0704);

        // Same-cycle CSR write must not affect the check of that cycle
        csr_wr(32'h3B0, 32'h0000_0010);
        csr_wr(32'h3B1, 32'h0000_03FF);
        csr_wr(32'h3A0, 32'h0000_1C00);
        rw_addr = 32'h3A0;
        wdata   = 32'h0000_1C09;
        wr_en   = 1'b1;
        drive(0, 32'h0010, OPER_READ, SIZE_WORD, PRIV_U, 1'b1);
        cycle();
        drive(0, 32'h0010, OPER_READ, SIZE_WORD, PRIV_U, 1'b0);
        cycle();

        // Reset with requests in flight drops them and clears locked entries
        bus.req_valid = 2'b11;
        bus.req_addr  = '0;
        reset         = 1'b1;
        cycle();
        chk("midrst_rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
        reset = 1'b0;
        csr_chk("midrst_cfg0", 32'h3A0, 32'h0);
        csr_chk("midrst_addr2", 32'h3B2, 32'h0);
        chk("midrst_fault_valid", {31'b0, fault_valid}, 32'd0);
        cycle();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
